// File: rtl/iter_div_axis.sv
// Iterative radix-2 restoring divider with AXI-stream-style divisor/dividend/dout channels.
// One quotient bit per cycle; signed or unsigned operation chosen at elaboration.
module iter_div_axis #(
  parameter bit          SIGNED = 1'b1,
  parameter int unsigned WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     s_axis_divisor_tdata,
  input  logic                 s_axis_divisor_tvalid,
  output logic                 s_axis_divisor_tready,
  input  logic [WIDTH-1:0]     s_axis_dividend_tdata,
  input  logic                 s_axis_dividend_tvalid,
  output logic                 s_axis_dividend_tready,
  output logic [2*WIDTH-1:0]   m_axis_dout_tdata,
  output logic                 m_axis_dout_tvalid
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [WIDTH-1:0] dvnd_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic             dz_q;
  logic             ready_q;

  logic             a_neg, b_neg, accept;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] diff, rem_nx, quo_nx, q_fin, r_fin;

  assign s_axis_divisor_tready  = ready_q;
  assign s_axis_dividend_tready = ready_q;

  assign accept = (state_q == StIdle) && s_axis_divisor_tvalid && s_axis_dividend_tvalid;

  always_comb begin
    a_neg = SIGNED && s_axis_dividend_tdata[WIDTH-1];
    b_neg = SIGNED && s_axis_divisor_tdata[WIDTH-1];
    // Magnitude of the most negative value wraps to itself, which is correct as unsigned.
    a_mag = a_neg ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
    b_mag = b_neg ? -s_axis_divisor_tdata : s_axis_divisor_tdata;

    rem_sh = {rem_q, quo_q[WIDTH-1]};
    ge     = rem_sh >= {1'b0, dvsr_q};
    diff   = rem_sh[WIDTH-1:0] - dvsr_q;
    rem_nx = ge ? diff : rem_sh[WIDTH-1:0];
    quo_nx = {quo_q[WIDTH-2:0], ge};

    q_fin = q_neg_q ? -quo_nx : quo_nx;
    r_fin = r_neg_q ? -rem_nx : rem_nx;
    if (dz_q) begin
      q_fin = '1;
      r_fin = dvnd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= StIdle;
      cnt_q              <= '0;
      rem_q              <= '0;
      quo_q              <= '0;
      dvsr_q             <= '0;
      dvnd_q             <= '0;
      q_neg_q            <= 1'b0;
      r_neg_q            <= 1'b0;
      dz_q               <= 1'b0;
      ready_q            <= 1'b1;
      m_axis_dout_tvalid <= 1'b0;
      m_axis_dout_tdata  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StCalc;
            cnt_q   <= CW'(WIDTH);
            rem_q   <= '0;
            quo_q   <= a_mag;
            dvsr_q  <= b_mag;
            dvnd_q  <= s_axis_dividend_tdata;
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
            dz_q    <= (s_axis_divisor_tdata == '0);
            ready_q <= 1'b0;
          end
        end
        StCalc: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q            <= StDone;
            m_axis_dout_tvalid <= 1'b1;
            m_axis_dout_tdata  <= {q_fin, r_fin};
          end
        end
        StDone: begin
          state_q            <= StIdle;
          m_axis_dout_tvalid <= 1'b0;
          ready_q            <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_div_axis.sv
// Directed bench for iter_div_axis: one unsigned and one signed instance on shared inputs.
module tb_iter_div_axis;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dvsr, dvnd;
  logic        dvsr_v, dvnd_v;
  logic        u_rdy_a, u_rdy_b, s_rdy_a, s_rdy_b;
  logic [63:0] u_data, s_data;
  logic        u_vld, s_vld;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  iter_div_axis #(.SIGNED(1'b0), .WIDTH(32)) u_udiv (
    .clk                    (clk),
    .rst                    (rst),
    .s_axis_divisor_tdata   (dvsr),
    .s_axis_divisor_tvalid  (dvsr_v),
    .s_axis_divisor_tready  (u_rdy_a),
    .s_axis_dividend_tdata  (dvnd),
    .s_axis_dividend_tvalid (dvnd_v),
    .s_axis_dividend_tready (u_rdy_b),
    .m_axis_dout_tdata      (u_data),
    .m_axis_dout_tvalid     (u_vld)
  );

  iter_div_axis #(.SIGNED(1'b1), .WIDTH(32)) u_sdiv (
    .clk                    (clk),
    .rst                    (rst),
    .s_axis_divisor_tdata   (dvsr),
    .s_axis_divisor_tvalid  (dvsr_v),
    .s_axis_divisor_tready  (s_rdy_a),
    .s_axis_dividend_tdata  (dvnd),
    .s_axis_dividend_tvalid (dvnd_v),
    .s_axis_dividend_tready (s_rdy_b),
    .m_axis_dout_tdata      (s_data),
    .m_axis_dout_tvalid     (s_vld)
  );

  typedef struct {
    string       name;
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Accepts one operand pair, then checks latency, result, pulse width and tready return.
  task automatic run_div(input string name, input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] q, input logic [31:0] r);
    int lat;
    dvnd = a; dvsr = b; dvnd_v = 1'b1; dvsr_v = 1'b1;
    tick();
    dvnd_v = 1'b0; dvsr_v = 1'b0;
    dvnd = 32'hdead_beef; dvsr = 32'h0bad_cafe;
    check({name, " tready_low"}, {62'd0, sgn ? s_rdy_a : u_rdy_a, sgn ? s_rdy_b : u_rdy_b}, 64'd0);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) tick();
      if (c == 1) tick();
      if (sgn ? s_vld : u_vld) begin
        lat = c;
        break;
      end
    end
    check({name, " latency"}, 64'(lat), 64'd32);
    check({name, " result"}, sgn ? s_data : u_data, {q, r});
    tick();
    check({name, " pulse_end"}, {62'd0, sgn ? s_vld : u_vld, sgn ? s_rdy_a : u_rdy_a}, 64'd1);
  endtask

  initial begin
    vecs.push_back('{"u_100_7",    1'b0, 32'd100,        32'd7,          32'd14,         32'd2});
    vecs.push_back('{"u_dz",       1'b0, 32'h1234_5678,  32'd0,          32'hffff_ffff,  32'h1234_5678});
    vecs.push_back('{"s_dz",       1'b1, 32'h1234_5678,  32'd0,          32'hffff_ffff,  32'h1234_5678});
    vecs.push_back('{"s_dz_neg",   1'b1, 32'h8000_0000,  32'd0,          32'hffff_ffff,  32'h8000_0000});
    vecs.push_back('{"u_max_1",    1'b0, 32'hffff_ffff,  32'd1,          32'hffff_ffff,  32'd0});
    vecs.push_back('{"s_m7_2",     1'b1, 32'hffff_fff9,  32'd2,          32'hffff_fffd,  32'hffff_ffff});
    vecs.push_back('{"s_7_m2",     1'b1, 32'd7,          32'hffff_fffe,  32'hffff_fffd,  32'd1});
    vecs.push_back('{"s_ovf",      1'b1, 32'h8000_0000,  32'hffff_ffff,  32'h8000_0000,  32'd0});
    vecs.push_back('{"s_m100_m7",  1'b1, 32'hffff_ff9c,  32'hffff_fff9,  32'd14,         32'hffff_fffe});
    vecs.push_back('{"s_m6_3",     1'b1, 32'hffff_fffa,  32'd3,          32'hffff_fffe,  32'd0});
    vecs.push_back('{"u_big",      1'b0, 32'hffff_ffff,  32'h0001_0000,  32'h0000_ffff,  32'h0000_ffff});
    vecs.push_back('{"u_small",    1'b0, 32'd5,          32'd9,          32'd0,          32'd5});

    rst = 1'b1; dvsr = '0; dvnd = '0; dvsr_v = 1'b0; dvnd_v = 1'b0;
    repeat (3) tick();
    check("reset_u", {u_data[31:0], 29'd0, u_vld, u_rdy_a, u_rdy_b}, 64'd3);
    check("reset_u_data", u_data, 64'd0);
    check("reset_s", {s_data[31:0], 29'd0, s_vld, s_rdy_a, s_rdy_b}, 64'd3);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_div(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);

    // Lone dividend valid must not start anything.
    begin
      int bad = 0;
      dvnd = 32'd50; dvsr = 32'd5; dvnd_v = 1'b1;
      for (int c = 0; c < 5; c++) begin
        tick();
        if (!u_rdy_a || u_vld) bad++;
      end
      check("lone_valid_ignored", 64'(bad), 64'd0);
    end

    // Valids held throughout; operands change during CALC; back-to-back accepts 34 apart.
    begin
      int lat, bad;
      dvsr_v = 1'b1;
      tick();
      check("hs_accept", {63'd0, u_rdy_a}, 64'd0);
      dvnd = 32'd1000; dvsr = 32'd3;
      lat = 0; bad = 0;
      for (int c = 1; c <= 40; c++) begin
        tick();
        if (u_rdy_a) bad++;
        if (u_vld) begin lat = c; break; end
      end
      check("hs_latency", 64'(lat), 64'd32);
      check("hs_no_early_accept", 64'(bad), 64'd0);
      check("hs_result", u_data, {32'd10, 32'd0});
      tick();
      check("b2b_ready_window_open", {62'd0, u_vld, u_rdy_a}, 64'd1);
      tick();
      check("b2b_ready_window_close", {63'd0, u_rdy_a}, 64'd0);
      lat = 2; bad = 0;
      for (int c = 3; c <= 50; c++) begin
        tick();
        if (u_vld) begin lat = c; break; end
        if (u_data !== {32'd10, 32'd0}) bad++;
      end
      check("b2b_spacing", 64'(lat), 64'd34);
      check("b2b_tdata_stable", 64'(bad), 64'd0);
      check("b2b_result", u_data, {32'd333, 32'd1});
      dvsr_v = 1'b0; dvnd_v = 1'b0;
      repeat (2) tick();
    end

    // Reset at cycle 10 of CALC abandons the divide.
    begin
      int pulses = 0;
      dvnd = 32'd12345; dvsr = 32'd67; dvnd_v = 1'b1; dvsr_v = 1'b1;
      tick();
      dvnd_v = 1'b0; dvsr_v = 1'b0;
      repeat (9) tick();
      rst = 1'b1; dvnd_v = 1'b1; dvsr_v = 1'b1;
      tick();
      rst = 1'b0; dvnd_v = 1'b0; dvsr_v = 1'b0;
      check("rst_mid_outputs", {u_data[31:0], 30'd0, u_vld, u_rdy_a}, 64'd1);
      check("rst_mid_data", u_data, 64'd0);
      for (int c = 0; c < 30; c++) begin
        tick();
        if (u_vld) pulses++;
      end
      check("rst_mid_no_pulse", 64'(pulses), 64'd0);
      run_div("after_rst", 1'b0, 32'd200, 32'd10, 32'd20, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
